// File: rtl/word_transmitter_if.sv
// word_transmitter_if: request handshake plus two-wire serial link of word_transmitter.
interface word_transmitter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic valid;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [DATA_WIDTH-1:0] word_in;
  logic ready;
  logic busy;
  logic done;
  logic data_on_pin;
  logic data_pin;
  modport master (
    output valid, addr_in, word_in,
    input  ready, busy, done, data_on_pin, data_pin
  );
  modport slave (
    input  valid, addr_in, word_in,
    output ready, busy, done, data_on_pin, data_pin
  );
endinterface

// File: rtl/word_transmitter.sv
// word_transmitter: serialises one {address, data} pair MSB first onto a strobe/data link.
module word_transmitter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int SETUP_CYCLES = 2,
  parameter int HIGH_CYCLES  = 4,
  parameter int LOW_CYCLES   = 4,
  parameter int GAP_CYCLES   = 16
) (
  input logic clock,
  input logic reset,
  word_transmitter_if.slave bus
);
  localparam int N = ADDR_WIDTH + DATA_WIDTH;
  localparam int M1 = SETUP_CYCLES > HIGH_CYCLES ? SETUP_CYCLES : HIGH_CYCLES;
  localparam int M2 = LOW_CYCLES > GAP_CYCLES ? LOW_CYCLES : GAP_CYCLES;
  localparam int PMAX = M1 > M2 ? M1 : M2;
  localparam int PW = $clog2(PMAX + 1);
  localparam int BW = $clog2(N + 1);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE_HI, STROBE_LO, GAP} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [N-1:0] sh_q, sh_d;
  logic ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic strobe_q, strobe_d, data_q, data_d;
  logic phase_end;
  assign phase_end = cnt_q == (state_q == SETUP     ? PW'(SETUP_CYCLES - 1) :
                               state_q == STROBE_HI ? PW'(HIGH_CYCLES - 1)  :
                               state_q == STROBE_LO ? PW'(LOW_CYCLES - 1)   :
                                                      PW'(GAP_CYCLES - 1));
  always_comb begin
    state_d  = state_q;
    cnt_d    = phase_end ? '0 : cnt_q + 1'b1;
    bit_d    = bit_q;
    sh_d     = sh_q;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    strobe_d = strobe_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        cnt_d   = '0;
        if (bus.valid && ready_q) begin
          state_d = SETUP;
          ready_d = 1'b0;
          sh_d    = {bus.addr_in, bus.word_in};
          bit_d   = '0;
          data_d  = bus.addr_in[ADDR_WIDTH-1];
        end
      end
      SETUP: if (phase_end) begin
        state_d  = STROBE_HI;
        strobe_d = 1'b1;
      end
      STROBE_HI: if (phase_end) begin
        state_d  = STROBE_LO;
        strobe_d = 1'b0;
      end
      STROBE_LO: if (phase_end) begin
        if (bit_q == BW'(N - 1)) begin
          state_d = GAP;
          bit_d   = BW'(N);
          data_d  = 1'b0;
        end else begin
          state_d = SETUP;
          bit_d   = bit_q + 1'b1;
          sh_d    = sh_q << 1;
          data_d  = sh_q[N-2];
        end
      end
      GAP: if (phase_end) begin
        state_d = IDLE;
        ready_d = 1'b1;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = ~ready_d;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      data_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
    end
  end
  assign bus.ready       = ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.data_on_pin = strobe_q;
  assign bus.data_pin    = data_q;
endmodule

// File: tb/tb_word_transmitter.sv
// tb_word_transmitter: directed checks of frame timing, bit order, handshake and reset.
module tb_word_transmitter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  word_transmitter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();
  word_transmitter dut (.clock(clk), .reset(rst), .bus(bus));
  int total = 0;
  int fails = 0;
  int rises = 0;
  int dones = 0;
  int viol = 0;
  logic [87:0] cap = '0;
  logic prev_s = 1'b0;
  logic prev_d = 1'b0;
  always @(negedge clk) begin
    if (bus.data_on_pin && !prev_s) begin
      rises = rises + 1;
      cap = {cap[86:0], bus.data_pin};
    end
    if (bus.data_on_pin && bus.data_pin !== prev_d) viol = viol + 1;
    if (bus.done) dones = dones + 1;
    prev_s = bus.data_on_pin;
    prev_d = bus.data_pin;
  end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [11:0] a, input logic [31:0] w);
    bus.valid = 1'b1;
    bus.addr_in = a;
    bus.word_in = w;
    tick();
    bus.valid = 1'b0;
  endtask
  task automatic wait_done(input int start, output int k);
    k = start;
    while (!bus.done && k < 600) begin
      tick();
      k++;
    end
  endtask
  int k, r0, d0;
  initial begin
    bus.valid = 1'b0;
    bus.addr_in = '0;
    bus.word_in = '0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ready", 88'(bus.ready), 88'(1));
    check("rst_busy", 88'(bus.busy), 88'(0));
    check("rst_done", 88'(bus.done), 88'(0));
    check("rst_strobe", 88'(bus.data_on_pin), 88'(0));
    check("rst_data", 88'(bus.data_pin), 88'(0));
    rst = 1'b0;
    tick();
    // single frame
    r0 = rises; d0 = dones;
    send(12'h005, 32'hDEADBEEF);
    check("t2_busy", 88'(bus.busy), 88'(1));
    check("t2_ready", 88'(bus.ready), 88'(0));
    check("t2_first_bit", 88'(bus.data_pin), 88'(0));
    wait_done(1, k);
    check("t2_done_cycle", 88'(k), 88'(457));
    check("t2_done_ready", 88'(bus.ready), 88'(1));
    tick();
    check("t2_done_pulse", 88'(bus.done), 88'(0));
    check("t2_rises", 88'(rises - r0), 88'(44));
    check("t2_bits", 88'(cap[43:0]), 88'(44'h005DEADBEEF));
    check("t2_dones", 88'(dones - d0), 88'(1));
    // valid held across two frames
    r0 = rises; d0 = dones;
    bus.valid = 1'b1;
    bus.addr_in = 12'h001;
    bus.word_in = 32'h00000001;
    tick();
    wait_done(1, k);
    check("t3_done1_cycle", 88'(k), 88'(457));
    bus.addr_in = 12'hFFF;
    bus.word_in = 32'hFFFFFFFF;
    tick();
    check("t3_b2b_accept", 88'(bus.ready), 88'(0));
    bus.valid = 1'b0;
    wait_done(1, k);
    check("t3_done2_cycle", 88'(k), 88'(457));
    tick();
    check("t3_rises", 88'(rises - r0), 88'(88));
    check("t3_bits", cap, {44'h00100000001, 44'hFFFFFFFFFFF});
    check("t3_dones", 88'(dones - d0), 88'(2));
    // valid pulsed while busy
    r0 = rises; d0 = dones;
    send(12'h3C5, 32'hA5A50F0F);
    k = 1;
    while (k < 100) begin tick(); k++; end
    bus.valid = 1'b1;
    bus.addr_in = 12'h123;
    bus.word_in = 32'h0;
    tick();
    bus.valid = 1'b0;
    check("t4_still_busy", 88'(bus.busy), 88'(1));
    wait_done(101, k);
    check("t4_done_cycle", 88'(k), 88'(457));
    repeat (20) tick();
    check("t4_idle_after", 88'(bus.ready), 88'(1));
    check("t4_rises", 88'(rises - r0), 88'(44));
    check("t4_bits", 88'(cap[43:0]), 88'(44'h3C5A5A50F0F));
    check("t4_dones", 88'(dones - d0), 88'(1));
    // reset during bit 20 (cycles 201..210)
    send(12'h2F0, 32'h00F00001);
    repeat (204) tick();
    check("t5_mid_strobe", 88'(bus.data_on_pin), 88'(1));
    check("t5_mid_data", 88'(bus.data_pin), 88'(1));
    rst = 1'b1;
    tick();
    check("t5_rst_strobe", 88'(bus.data_on_pin), 88'(0));
    check("t5_rst_data", 88'(bus.data_pin), 88'(0));
    check("t5_rst_ready", 88'(bus.ready), 88'(1));
    check("t5_rst_busy", 88'(bus.busy), 88'(0));
    rst = 1'b0;
    tick();
    r0 = rises;
    send(12'h0AA, 32'h12345678);
    wait_done(1, k);
    check("t5_done_cycle", 88'(k), 88'(457));
    tick();
    check("t5_rises", 88'(rises - r0), 88'(44));
    check("t5_bits", 88'(cap[43:0]), 88'(44'h0AA12345678));
    // four back-to-back words to addresses 0..3
    d0 = dones;
    for (int i = 0; i < 4; i++) begin
      send(12'(i), 32'(32'hC0DE0000 + 32'(i) * 32'h1111));
      wait_done(1, k);
      check("t6_done_cycle", 88'(k), 88'(457));
      check("t6_word", 88'(cap[43:0]), 88'({12'(i), 32'(32'hC0DE0000 + 32'(i) * 32'h1111)}));
    end
    tick();
    check("t6_dones", 88'(dones - d0), 88'(4));
    check("strobe_stable_data", 88'(viol), 88'(0));
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
